// File: rtl/lab8_soc_pio_in_edge.sv
// lab8_soc_pio_in_edge
//   Avalon-MM input PIO with a WIDTH-bit input port, an N-stage synchroniser,
//   per-bit edge capture, a per-bit interrupt mask and a level interrupt.
//   Optional build macro: PIO_IN_BIT_CLEAR_EN. When it is defined, a write to
//   edgecapture clears only the bits written as 1. When it is not defined, any
//   write to edgecapture clears every bit.
//
//   Bus timing: a write takes effect at the clk edge where
//   (chipselect & ~write_n) is high. readdata is registered every cycle from
//   address, so it is valid the cycle after address is presented. There are
//   no wait states and no read strobe, and reads have no side effects.
module lab8_soc_pio_in_edge #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecapture_q;
  logic [ARM_W-1:0] arm_cnt_q;
  logic             armed;
  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_next;

  assign level = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt_q == ARM_MAX);
  assign wr_en = chipselect & ~write_n;

  // Synchroniser chain: in_port enters stage 0 and moves one stage per clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Previous synchronised level, used for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= level;
  end

  // Arm counter: holds edge detection off until the chain and prev have
  // filled, so inputs that are already high at reset release do not look
  // like edges.
  always_ff @(posedge clk) begin
    if (!reset_n)    arm_cnt_q <= '0;
    else if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
  end

  // Edge selection by EDGE_TYPE, gated by the arm counter.
  always_comb begin
    rise = level & ~prev_q;
    fall = ~level & prev_q;
    ev   = '0;
    if (EDGE_TYPE == 0)      ev = rise;
    else if (EDGE_TYPE == 1) ev = fall;
    else                     ev = rise | fall;
    if (!armed) ev = '0;
  end

  // Clear mask for edgecapture writes.
  always_comb begin
    clr_mask = '0;
    if (wr_en && address == 2'd3) begin
`ifdef PIO_IN_BIT_CLEAR_EN
      clr_mask = writedata[WIDTH-1:0];
`else
      clr_mask = '1;
`endif
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (!reset_n)                        irqmask_q <= '0;
    else if (wr_en && address == 2'd2)   irqmask_q <= writedata[WIDTH-1:0];
  end

  // Edge capture: a new event is ORed in after the clear, so a set in the
  // same cycle as a clear wins and no edge is ever lost.
  always_ff @(posedge clk) begin
    if (!reset_n) edgecapture_q <= '0;
    else          edgecapture_q <= (edgecapture_q & ~clr_mask) | ev;
  end

  // Read mux, zero-extended to 32 bits.
  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = level;
      2'd2:    rd_next[WIDTH-1:0] = irqmask_q;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture_q;
      default: rd_next = '0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edgecapture_q & irqmask_q);

endmodule
